// File: rtl/pc_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned DefaultAddrW      = 32;
  localparam logic [31:0] DefaultResetPc    = 32'h0000_0000;
  localparam int unsigned DefaultInstrBytes = 4;

  typedef enum logic [1:0] {
    StReset,
    StFetch,
    StExec,
    StHalted
  } pc_state_e;

  // Next-PC source, listed from lowest to highest priority.
  typedef enum logic [1:0] {
    SelSeq,
    SelBr,
    SelJmp,
    SelJr
  } pc_sel_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority select: jr > jmp > branch > sequential.
// Taken targets are word-aligned and a misalignment is reported.
module next_pc_mux import pc_pkg::*; #(
  parameter int unsigned ADDR_W      = DefaultAddrW,
  parameter int unsigned INSTR_BYTES = DefaultInstrBytes
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jmp_i,
  input  logic              jr_i,
  input  logic              branch_taken_i,
  input  logic [ADDR_W-1:0] imm_target_i,
  input  logic [ADDR_W-1:0] reg_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] seq_pc_o,
  output pc_sel_e           sel_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0] target;
  logic              taken;

  // Priority select, then align the chosen target and flag dropped low bits.
  always_comb begin
    sel_o    = SelSeq;
    target   = imm_target_i;
    seq_pc_o = pc_i + ADDR_W'(INSTR_BYTES);
    if (jr_i) begin
      sel_o  = SelJr;
      target = reg_target_i;
    end else if (jmp_i) begin
      sel_o = SelJmp;
    end else if (branch_taken_i) begin
      sel_o = SelBr;
    end
    taken      = (sel_o != SelSeq);
    misalign_o = taken && (target[1:0] != 2'b00);
    next_pc_o  = taken ? {target[ADDR_W-1:2], 2'b00} : seq_pc_o;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch/execute sequencer for the unpipelined core.
// Optional feature macro: PC_JUMP_COUNT_EN (counts taken control transfers).
module pc_sequencer import pc_pkg::*; #(
  parameter int unsigned        ADDR_W      = DefaultAddrW,
  parameter logic [ADDR_W-1:0]  RESET_PC    = ADDR_W'(DefaultResetPc),
  parameter int unsigned        INSTR_BYTES = DefaultInstrBytes
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  input  logic              jmp,
  input  logic              jr,
  input  logic              jal,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] imm_target,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              halt,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              misalign,
  output logic [15:0]       jump_count
);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic              link_we_q;
  logic [ADDR_W-1:0] link_data_q;
  logic              misalign_q;

  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] seq_pc;
  pc_sel_e           sel;
  logic              target_misalign;
  logic              exec_go;

  next_pc_mux #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_pc_mux (
    .pc_i           (pc_q),
    .jmp_i          (jmp),
    .jr_i           (jr),
    .branch_taken_i (branch_taken),
    .imm_target_i   (imm_target),
    .reg_target_i   (reg_target),
    .next_pc_o      (next_pc),
    .seq_pc_o       (seq_pc),
    .sel_o          (sel),
    .misalign_o     (target_misalign)
  );

  // Next-state and state-decoded outputs.
  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    exec_go     = 1'b0;
    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = StExec;
      end
      StExec: begin
        instr_valid = 1'b1;
        // A halting instruction commits nothing but the state change.
        exec_go     = !halt;
        state_d     = halt ? StHalted : StFetch;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StReset;
    endcase
  end

  // State, PC, link and misalign registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReset;
      pc_q        <= RESET_PC;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      link_we_q <= exec_go && jal;
      if (exec_go) begin
        pc_q <= next_pc;
        if (jal) link_data_q <= seq_pc;
        if (target_misalign) misalign_q <= 1'b1;
      end
    end
  end

  assign pc        = pc_q;
  assign link_we   = link_we_q;
  assign link_data = link_data_q;
  assign misalign  = misalign_q;

`ifdef PC_JUMP_COUNT_EN
  logic [15:0] jump_count_q;

  // Saturating count of redirected EXEC cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      jump_count_q <= '0;
    end else if (exec_go && (sel != SelSeq) && (jump_count_q != 16'hFFFF)) begin
      jump_count_q <= jump_count_q + 16'd1;
    end
  end

  assign jump_count = jump_count_q;
`else
  logic unused_sel;
  assign unused_sel = ^sel;
  assign jump_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver pushes expected EXEC pc and
// link writes, a negedge monitor pops and compares them as the DUT presents them.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] pc;
  logic        instr_valid;
  logic        jmp, jr, jal, branch_taken, halt;
  logic [31:0] imm_target, reg_target;
  logic        link_we;
  logic [31:0] link_data;
  logic        misalign;
  logic [15:0] jump_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_link_q[$];
  logic [31:0] cur_pc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .jmp          (jmp),
    .jr           (jr),
    .jal          (jal),
    .branch_taken (branch_taken),
    .imm_target   (imm_target),
    .reg_target   (reg_target),
    .halt         (halt),
    .link_we      (link_we),
    .link_data    (link_data),
    .misalign     (misalign),
    .jump_count   (jump_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Monitor: every EXEC and every link write must match the head of its queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (instr_valid === 1'b1) begin
        if (exp_pc_q.size() == 0) check("unexpected_exec", pc, 32'hxxxx_xxxx);
        else check("exec_pc", pc, exp_pc_q.pop_front());
      end
      if (link_we === 1'b1) begin
        if (exp_link_q.size() == 0) check("unexpected_link", link_data, 32'hxxxx_xxxx);
        else check("link_data", link_data, exp_link_q.pop_front());
      end
    end
  end

  task automatic clear_inputs();
    jmp = 0; jr = 0; jal = 0; branch_taken = 0; halt = 0;
    imm_target = '0; reg_target = '0;
  endtask

  // One instruction: wait for fetch, stall `delay` cycles, then present the
  // decoder outputs during EXEC. next_pc and link values are hand-computed.
  task automatic do_instr(input bit j, input bit r, input bit l, input bit b, input bit h,
                          input logic [31:0] imm, input logic [31:0] rt, input int delay,
                          input logic [31:0] exp_next, input bit exp_link,
                          input logic [31:0] exp_link_val);
    int guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (imem_req !== 1'b1) begin
      check("fetch_timeout", {31'b0, imem_req}, 32'd1);
      return;
    end
    for (int i = 0; i < delay; i++) begin
      imem_ready = 1'b0;
      check("stall_req", {31'b0, imem_req}, 32'd1);
      check("stall_pc", pc, cur_pc);
      @(negedge clk);
    end
    exp_pc_q.push_back(cur_pc);
    if (exp_link) exp_link_q.push_back(exp_link_val);
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    jmp = j; jr = r; jal = l; branch_taken = b; halt = h;
    imm_target = imm; reg_target = rt;
    @(negedge clk);
    clear_inputs();
    check("next_pc", pc, exp_next);
    cur_pc = exp_next;
  endtask

  task automatic do_reset(input logic ready_during);
    rst = 1'b1;
    imem_ready = ready_during;
    clear_inputs();
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_link_we", {31'b0, link_we}, 32'd0);
    check("rst_link_data", link_data, 32'h0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_jump_count", {16'b0, jump_count}, 32'd0);
    imem_ready = 1'b0;
    rst = 1'b0;
    cur_pc = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_count;
    do_reset(1'b0);

    // Sequential: 0,4,8,12 then to 0x10.
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h04, 0, 32'h0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h08, 0, 32'h0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0C, 0, 32'h0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h10, 0, 32'h0);
    // JAL at 0x10 to 0x200, links 0x14.
    do_instr(1, 0, 1, 0, 0, 32'h200, 32'h0, 0, 32'h200, 1, 32'h14);
    // jr+jmp+jal: jr wins, links 0x204.
    do_instr(1, 1, 1, 0, 0, 32'h40, 32'h80, 0, 32'h80, 1, 32'h204);
    // Five-cycle fetch stall, sequential.
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 5, 32'h84, 0, 32'h0);
    // Taken branch.
    do_instr(0, 0, 0, 1, 0, 32'h300, 32'h0, 0, 32'h300, 0, 32'h0);
    check("misalign_clean", {31'b0, misalign}, 32'd0);
    // jal alone links and advances sequentially.
    do_instr(0, 0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h304, 1, 32'h304);
    // Halt with jal and jmp: nothing commits, pc frozen.
    do_instr(1, 0, 1, 0, 1, 32'h500, 32'h0, 0, 32'h304, 0, 32'h0);
    repeat (4) @(negedge clk);
    check("halt_pc", pc, 32'h304);
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
`ifdef PC_JUMP_COUNT_EN
    exp_count = 32'd3;
`else
    exp_count = 32'd0;
`endif
    check("jump_count_halt", {16'b0, jump_count}, exp_count);

    // Reset while ready is asserted: the in-flight word is ignored.
    do_reset(1'b1);

    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h04, 0, 32'h0);
    // Misaligned jr target 0x103 -> 0x100, sticky flag.
    do_instr(0, 1, 0, 0, 0, 32'h0, 32'h103, 0, 32'h100, 0, 32'h0);
    check("misalign_set", {31'b0, misalign}, 32'd1);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h104, 0, 32'h0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h108, 0, 32'h0);
    do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h10C, 0, 32'h0);
    check("misalign_sticky", {31'b0, misalign}, 32'd1);
`ifdef PC_JUMP_COUNT_EN
    exp_count = 32'd1;
`else
    exp_count = 32'd0;
`endif
    check("jump_count_after", {16'b0, jump_count}, exp_count);
    do_reset(1'b0);

    repeat (2) @(negedge clk);
    check("pc_queue_drained", exp_pc_q.size(), 32'd0);
    check("link_queue_drained", exp_link_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
